spi_slave_ctrl: RTL and testbench

//  Transaction sequencer for the SPI slave shift register. Frames SS_n transactions, counts bits,

---
 rtl/spi_slave_pkg.sv | 18 +
 rtl/spi_slave_bitcnt.sv | 32 +++
 rtl/spi_slave_ctrl.sv | 118 +++++++++++
 tb/tb_spi_slave_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_slave_pkg.sv
// Shared definitions for the SPI slave: default widths, opcodes and the sequencer state encoding.
package spi_slave_pkg;

  localparam int unsigned DEF_WIDTH  = 8;
  localparam logic [7:0]  DEF_OPC_WR = 8'h02;
  localparam logic [7:0]  DEF_OPC_RD = 8'h03;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_OPCODE = 3'd1,
    ST_ADDR   = 3'd2,
    ST_WDATA  = 3'd3,
    ST_RDATA  = 3'd4,
    ST_DONE   = 3'd5,
    ST_IGNORE = 3'd6
  } state_t;

endpackage

// File: rtl/spi_slave_bitcnt.sv
// Mod-WIDTH bit counter for the SPI slave; clears while SS_n is high.
// byte_done is registered and is high exactly while the count sits at WIDTH-1.
module spi_slave_bitcnt #(
  parameter int unsigned WIDTH = 8
) (
  input  logic CLK,
  input  logic RST,
  input  logic clr,
  output logic byte_done
);

  localparam int unsigned CW = $clog2(WIDTH);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;

  always_comb begin
    cnt_nxt = '0;
    if (!clr && (cnt != CW'(WIDTH - 1))) cnt_nxt = cnt + CW'(1);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt       <= '0;
      byte_done <= 1'b0;
    end else begin
      cnt       <= cnt_nxt;
      byte_done <= (cnt_nxt == CW'(WIDTH - 1));
    end
  end

endmodule

// File: rtl/spi_slave_ctrl.sv
// SPI slave transaction sequencer: opcode/address/data decode, register-file strobes, DataSel.
// Define SPI_BURST_EN for auto-incrementing multi-byte read/write bursts.
module spi_slave_ctrl
  import spi_slave_pkg::*;
#(
  parameter int unsigned      WIDTH  = DEF_WIDTH,
  parameter logic [WIDTH-1:0] OPC_WR = WIDTH'(DEF_OPC_WR),
  parameter logic [WIDTH-1:0] OPC_RD = WIDTH'(DEF_OPC_RD)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             SS_n,
  input  logic             MOSI,
  input  logic [WIDTH-1:0] Data_sh,
  output logic             DataSel,
  output logic             Rd_En,
  output logic             Wr_En,
  output logic [WIDTH-1:0] Addr,
  output logic [WIDTH-1:0] Wr_Data,
  output logic             Busy,
  output logic             Err
);

  state_t           state;
  logic             is_rd;
  logic             byte_done;
  logic [WIDTH-1:0] byte_now;

  // Byte as it stands after the current edge; the shifted-out MSB is dropped by the cast.
  assign byte_now = WIDTH'({Data_sh, MOSI});

  spi_slave_bitcnt #(.WIDTH(WIDTH)) u_bitcnt (
    .CLK       (CLK),
    .RST       (RST),
    .clr       (SS_n),
    .byte_done (byte_done)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= ST_IDLE;
      is_rd   <= 1'b0;
      DataSel <= 1'b1;
      Rd_En   <= 1'b0;
      Wr_En   <= 1'b0;
      Addr    <= '0;
      Wr_Data <= '0;
      Busy    <= 1'b0;
      Err     <= 1'b0;
    end else begin
      Rd_En   <= 1'b0;
      Wr_En   <= 1'b0;
      DataSel <= 1'b1;
      Busy    <= ~SS_n;
      if (SS_n) begin
        state <= ST_IDLE;
        Err   <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: state <= ST_OPCODE;
          ST_OPCODE: begin
            if (byte_done) begin
              if (byte_now == OPC_WR) begin
                is_rd <= 1'b0;
                state <= ST_ADDR;
              end else if (byte_now == OPC_RD) begin
                is_rd <= 1'b1;
                state <= ST_ADDR;
              end else begin
                Err   <= 1'b1;
                state <= ST_IGNORE;
              end
            end
          end
          ST_ADDR: begin
            if (byte_done) begin
              Addr <= byte_now;
              if (is_rd) begin
                Rd_En   <= 1'b1;
                DataSel <= 1'b0;
                state   <= ST_RDATA;
              end else begin
                state   <= ST_WDATA;
              end
            end
          end
          ST_WDATA: begin
`ifdef SPI_BURST_EN
            // Advance only after the register file has taken the write on this edge.
            if (Wr_En) Addr <= Addr + WIDTH'(1);
`endif
            if (byte_done) begin
              Wr_Data <= byte_now;
              Wr_En   <= 1'b1;
`ifndef SPI_BURST_EN
              state   <= ST_DONE;
`endif
            end
          end
          ST_RDATA: begin
            if (byte_done) begin
`ifdef SPI_BURST_EN
              Addr    <= Addr + WIDTH'(1);
              Rd_En   <= 1'b1;
              DataSel <= 1'b0;
`else
              state   <= ST_DONE;
`endif
            end
          end
          ST_DONE, ST_IGNORE: state <= state;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// Scoreboard bench for spi_slave_ctrl with a behavioural shift register and register file.
module tb_spi_slave_ctrl;

  localparam int unsigned W = 8;

  logic         CLK = 1'b0;
  logic         RST;
  logic         SS_n;
  logic         MOSI;
  logic [W-1:0] Data_sh = '0;
  logic         DataSel;
  logic         Rd_En;
  logic         Wr_En;
  logic [W-1:0] Addr;
  logic [W-1:0] Wr_Data;
  logic         Busy;
  logic         Err;

  spi_slave_ctrl dut (
    .CLK     (CLK),
    .RST     (RST),
    .SS_n    (SS_n),
    .MOSI    (MOSI),
    .Data_sh (Data_sh),
    .DataSel (DataSel),
    .Rd_En   (Rd_En),
    .Wr_En   (Wr_En),
    .Addr    (Addr),
    .Wr_Data (Wr_Data),
    .Busy    (Busy),
    .Err     (Err)
  );

  always #5 CLK = ~CLK;

  logic [W-1:0] mem [256];

  // Shift register model: shift on posedge, load read data on negedge when DataSel is low.
  always @(posedge CLK or negedge CLK) begin
    if (CLK) Data_sh <= {Data_sh[W-2:0], MOSI};
    else if (!DataSel) Data_sh <= mem[Addr];
  end

  typedef struct packed {
    logic         is_rd;
    logic [W-1:0] addr;
    logic [W-1:0] data;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;
  logic prev_stb = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every strobe must match the head of the expected queue.
  always @(negedge CLK) begin
    if (!RST) begin
      chk("datasel_vs_rden", {31'd0, DataSel}, {31'd0, ~Rd_En});
      if (Rd_En || Wr_En) begin
        checks++;
        if ((Rd_En && Wr_En) || prev_stb) begin
          errors++;
          $display("FAIL strobe_shape: rd=%b wr=%b prev=%b expected single one-cycle strobe",
                   Rd_En, Wr_En, prev_stb);
        end else if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_strobe: rd=%b wr=%b addr=%0h expected none", Rd_En, Wr_En, Addr);
        end else begin
          mon_e = q.pop_front();
          if ((Rd_En !== mon_e.is_rd) || (Addr !== mon_e.addr) ||
              (!mon_e.is_rd && (Wr_Data !== mon_e.data))) begin
            errors++;
            $display("FAIL strobe: got rd=%b addr=%0h wdata=%0h expected rd=%b addr=%0h wdata=%0h",
                     Rd_En, Addr, Wr_Data, mon_e.is_rd, mon_e.addr, mon_e.data);
          end
        end
      end
      prev_stb = Rd_En || Wr_En;
    end else begin
      prev_stb = 1'b0;
    end
  end

  task automatic push(input logic is_rd, input logic [W-1:0] a, input logic [W-1:0] d);
    exp_t e;
    e.is_rd = is_rd;
    e.addr  = a;
    e.data  = d;
    q.push_back(e);
  endtask

  task automatic clk_bit(input logic b, output logic miso);
    @(negedge CLK);
    SS_n = 1'b0;
    MOSI = b;
    #1 miso = Data_sh[W-1];
    @(posedge CLK);
  endtask

  task automatic send_bits(input logic [W-1:0] b, input int n, output logic [W-1:0] mo);
    logic m;
    mo = '0;
    for (int i = 0; i < n; i++) begin
      clk_bit(b[W-1-i], m);
      mo = {mo[W-2:0], m};
    end
  endtask

  task automatic end_frame;
    @(negedge CLK);
    SS_n = 1'b1;
    MOSI = 1'b0;
    @(posedge CLK);
    #1;
  endtask

  logic [W-1:0] mo;
  logic         tm;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = W'(i);
    mem[8'h2C] = 8'h5A;
    mem[8'h10] = 8'h11;
    mem[8'h11] = 8'h22;
    RST  = 1'b1;
    SS_n = 1'b1;
    MOSI = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_busy", {31'd0, Busy}, 32'd0);
    chk("rst_datasel", {31'd0, DataSel}, 32'd1);
    chk("rst_err", {31'd0, Err}, 32'd0);
    chk("rst_strobes", {30'd0, Rd_En, Wr_En}, 32'd0);
    chk("rst_addr", {24'd0, Addr}, 32'd0);
    @(negedge CLK);
    RST = 1'b0;

    // Single write 02/15/A5 plus trailing edge
    push(1'b0, 8'h15, 8'hA5);
    send_bits(8'h02, 8, mo);
    send_bits(8'h15, 8, mo);
    send_bits(8'hA5, 8, mo);
    #1;
    chk("wr_busy", {31'd0, Busy}, 32'd1);
    clk_bit(1'b0, tm);
    end_frame();
    chk("wr_idle_busy", {31'd0, Busy}, 32'd0);

    // Reset mid-frame after the address was latched
    send_bits(8'h02, 8, mo);
    send_bits(8'h44, 8, mo);
    send_bits(8'h99, 4, mo);
    #1;
    chk("mid_addr", {24'd0, Addr}, 32'h44);
    @(negedge CLK);
    #2 RST = 1'b1;
    #1;
    chk("mid_rst_busy", {31'd0, Busy}, 32'd0);
    chk("mid_rst_datasel", {31'd0, DataSel}, 32'd1);
    chk("mid_rst_addr", {24'd0, Addr}, 32'd0);
    chk("mid_rst_wdata", {24'd0, Wr_Data}, 32'd0);
    chk("mid_rst_strobes", {30'd0, Rd_En, Wr_En}, 32'd0);
    SS_n = 1'b1;
    @(negedge CLK);
    RST = 1'b0;

    // Read 03/2C, register file returns 0x5A
    push(1'b1, 8'h2C, 8'h00);
`ifdef SPI_BURST_EN
    push(1'b1, 8'h2D, 8'h00);
`endif
    send_bits(8'h03, 8, mo);
    send_bits(8'h2C, 8, mo);
    send_bits(8'h00, 8, mo);
    chk("rd_miso", {24'd0, mo}, 32'h5A);
    end_frame();

    // Unsupported opcode
    send_bits(8'h07, 8, mo);
    #1;
    chk("bad_err", {31'd0, Err}, 32'd1);
    chk("bad_busy", {31'd0, Busy}, 32'd1);
    send_bits(8'hFF, 8, mo);
    #1;
    chk("bad_err_hold", {31'd0, Err}, 32'd1);
    end_frame();
    chk("bad_err_clr", {31'd0, Err}, 32'd0);
    chk("bad_idle", {31'd0, Busy}, 32'd0);

    // Abort after 11 bits, then a normal write
    send_bits(8'h02, 8, mo);
    send_bits(8'hA0, 3, mo);
    end_frame();
    chk("abort_idle", {31'd0, Busy}, 32'd0);
    push(1'b0, 8'h01, 8'h33);
    send_bits(8'h02, 8, mo);
    send_bits(8'h01, 8, mo);
    send_bits(8'h33, 8, mo);
    clk_bit(1'b0, tm);
    end_frame();

`ifdef SPI_BURST_EN
    // Burst write wrapping 0xFF -> 0x00
    push(1'b0, 8'hFE, 8'hAA);
    push(1'b0, 8'hFF, 8'hBB);
    push(1'b0, 8'h00, 8'hCC);
    send_bits(8'h02, 8, mo);
    send_bits(8'hFE, 8, mo);
    send_bits(8'hAA, 8, mo);
    send_bits(8'hBB, 8, mo);
    send_bits(8'hCC, 8, mo);
    clk_bit(1'b0, tm);
    end_frame();

    // Burst read of two bytes; the second completion prefetches 0x12
    push(1'b1, 8'h10, 8'h00);
    push(1'b1, 8'h11, 8'h00);
    push(1'b1, 8'h12, 8'h00);
    send_bits(8'h03, 8, mo);
    send_bits(8'h10, 8, mo);
    send_bits(8'h00, 8, mo);
    chk("burst_rd0", {24'd0, mo}, 32'h11);
    send_bits(8'h00, 8, mo);
    chk("burst_rd1", {24'd0, mo}, 32'h22);
    end_frame();
`endif

    repeat (3) @(posedge CLK);
    #1;
    chk("queue_empty", q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
